// File: rtl/quiz_pkg.sv
// Shared encodings and widths for the quiz host console.
package quiz_pkg;

    localparam int unsigned PLAYER_W = 3;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned TIME_W   = 4;
    localparam int unsigned ROUND_W  = 5;

    // Buzzer strobes are active-low.
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_BUZZ   = 3'd2,
        S_ANSWER = 3'd3,
        S_JUDGE  = 3'd4,
        S_CHECK  = 3'd5,
        S_OVER   = 3'd6
    } state_t;

endpackage

// File: rtl/quiz_host_console_btn_edge_sync.sv
// Button conditioner: 2-FF synchronizer plus falling-edge (press) detector.
module btn_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic fall_c
);

    logic sync1;
    logic sync2;
    logic last;

    // Synchronize the raw button and keep one delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            last  <= 1'b1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            last  <= sync2;
        end
    end

    // One-cycle pulse when the synchronized button goes from released to pressed.
    always_comb fall_c = last & ~sync2;

endmodule

// File: rtl/quiz_host_console.sv
// Host-side sequencer for the four-player quiz buzzer.
module quiz_host_console
    import quiz_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned ANSWER_TIME = 10,
    parameter int unsigned MAX_ROUNDS  = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                host_go_n,
    input  logic                judge_ok_n,
    input  logic                judge_bad_n,
    input  logic [PLAYER_W-1:0] P,
    input  logic [PLAYER_W-1:0] winner,
    output logic                h,
    output logic                jt,
    output logic                jf,
    output logic [TIME_W-1:0]   time_left,
    output logic [ROUND_W-1:0]  round_cnt,
    output logic [STATE_W-1:0]  state_o,
    output logic                timeout,
    output logic                game_over
);

    localparam int unsigned         DIV_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0]   TIME_LOAD   = TIME_W'(ANSWER_TIME);
    localparam logic [ROUND_W-1:0]  ROUND_LIMIT = ROUND_W'(MAX_ROUNDS);
    localparam logic [ROUND_W-1:0]  ROUND_SAT   = '1;

    logic go_ev;
    logic ok_ev;
    logic bad_ev;

    state_t             state;
    state_t             state_d;
    logic               check_second;
    logic               verdict_ok_d;
    logic               expired_d;
    logic               h_d;
    logic               jt_d;
    logic               jf_d;
    logic [DIV_W-1:0]   div;

    btn_edge_sync u_go  (.clk(clk), .reset(reset), .btn_n(host_go_n),   .fall_c(go_ev));
    btn_edge_sync u_ok  (.clk(clk), .reset(reset), .btn_n(judge_ok_n),  .fall_c(ok_ev));
    btn_edge_sync u_bad (.clk(clk), .reset(reset), .btn_n(judge_bad_n), .fall_c(bad_ev));

    // State register; CHECK is held for two cycles to let the winner code settle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            check_second <= 1'b0;
        end else begin
            state        <= state_d;
            check_second <= (state == S_CHECK) && !check_second;
        end
    end

    // Next-state decision; verdict priority in ANSWER is correct > wrong > expiry.
    always_comb begin
        state_d      = state;
        verdict_ok_d = 1'b0;
        expired_d    = 1'b0;
        case (state)
            S_IDLE:   if (go_ev) state_d = S_ARM;
            S_ARM:    state_d = S_BUZZ;
            S_BUZZ:   if (P != '0) state_d = S_ANSWER;
            S_ANSWER: begin
                if (ok_ev) begin
                    state_d      = S_JUDGE;
                    verdict_ok_d = 1'b1;
                end else if (bad_ev) begin
                    state_d = S_JUDGE;
                end else if (time_left == '0) begin
                    state_d   = S_JUDGE;
                    expired_d = 1'b1;
                end
            end
            S_JUDGE:  state_d = S_CHECK;
            S_CHECK:  begin
                if (check_second) begin
                    state_d = ((winner != '0) || (round_cnt == ROUND_LIMIT)) ? S_OVER : S_IDLE;
                end
            end
            S_OVER:   state_d = S_OVER;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobe values for the coming cycle; at most one is active at a time.
    always_comb begin
        h_d  = STROBE_OFF;
        jt_d = STROBE_OFF;
        jf_d = STROBE_OFF;
        if (state_d == S_ARM) h_d = STROBE_ON;
        if (state_d == S_JUDGE) begin
            if (verdict_ok_d) jt_d = STROBE_ON;
            else              jf_d = STROBE_ON;
        end
    end

    // Registered outputs, tick divider, countdown and round counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h         <= STROBE_OFF;
            jt        <= STROBE_OFF;
            jf        <= STROBE_OFF;
            timeout   <= 1'b0;
            game_over <= 1'b0;
            time_left <= '0;
            round_cnt <= '0;
            div       <= '0;
        end else begin
            h         <= h_d;
            jt        <= jt_d;
            jf        <= jf_d;
            game_over <= (state_d == S_OVER);

            if (state_d == S_ARM)        timeout <= 1'b0;
            else if (state_d == S_JUDGE) timeout <= expired_d;

            if ((state == S_BUZZ) && (state_d == S_ANSWER)) begin
                time_left <= TIME_LOAD;
                div       <= '0;
            end else if (state == S_ANSWER) begin
                if (div == DIV_LAST) begin
                    div <= '0;
                    if (time_left != '0) time_left <= time_left - 1'b1;
                end else begin
                    div <= div + 1'b1;
                end
            end

            if ((state == S_JUDGE) && (round_cnt != ROUND_SAT)) round_cnt <= round_cnt + 1'b1;
        end
    end

    // Current state for display; driven straight from the state flops.
    always_comb state_o = state;

endmodule

// File: tb/tb_quiz_host_console.sv
// Self-checking bench for quiz_host_console with a round-level reference model.
module tb_quiz_host_console;

    localparam int TD  = 4;
    localparam int AT  = 3;
    localparam int MR  = 2;
    localparam int LIM = TD * AT;
    localparam int NONE = 1000;

    localparam int ST_IDLE = 0, ST_ARM = 1, ST_BUZZ = 2, ST_ANSWER = 3;
    localparam int ST_JUDGE = 4, ST_CHECK = 5, ST_OVER = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       host_go_n = 1'b1;
    logic       judge_ok_n = 1'b1;
    logic       judge_bad_n = 1'b1;
    logic [2:0] P = 3'd0;
    logic [2:0] winner = 3'd0;
    logic       h, jt, jf, timeout, game_over;
    logic [3:0] time_left;
    logic [4:0] round_cnt;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    // Reference model of the game-level status between rounds.
    int exp_rounds = 0;
    int exp_tl = 0;
    bit exp_timeout = 1'b0;
    bit exp_over = 1'b0;

    wire [16:0] obs = {h, jt, jf, timeout, game_over, state_o, round_cnt, time_left};

    quiz_host_console #(
        .TICK_DIV(TD), .ANSWER_TIME(AT), .MAX_ROUNDS(MR)
    ) dut (
        .clk(clk), .reset(reset),
        .host_go_n(host_go_n), .judge_ok_n(judge_ok_n), .judge_bad_n(judge_bad_n),
        .P(P), .winner(winner),
        .h(h), .jt(jt), .jf(jf), .time_left(time_left), .round_cnt(round_cnt),
        .state_o(state_o), .timeout(timeout), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] vec(input logic eh, input logic ejt, input logic ejf,
                                        input logic eto, input logic ego, input int st,
                                        input int rc, input int tl);
        return {eh, ejt, ejf, eto, ego, 3'(st), 5'(rc), 4'(tl)};
    endfunction

    task automatic apply_reset(input string name);
        logic [16:0] e;
        @(negedge clk);
        reset = 1'b0;
        host_go_n = 1'b1; judge_ok_n = 1'b1; judge_bad_n = 1'b1;
        P = 3'd0; winner = 3'd0;
        #1;
        e = vec(1, 1, 1, 0, 0, ST_IDLE, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL %s got %b want %b", name, obs, e);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_rounds = 0; exp_tl = 0; exp_timeout = 1'b0; exp_over = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [16:0] e;
        apply_reset("reset_values");
        e = vec(1, 1, 1, 0, 0, ST_IDLE, 0, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_idle k=%0d got %b want %b", k, obs, e);
            end
        end
    endtask

    // Press "next question" and check h pulses exactly on the third cycle.
    task automatic start_round(input string name);
        logic [16:0] e;
        int st;
        host_go_n = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            st = (k < 3) ? ST_IDLE : (k == 3) ? ST_ARM : ST_BUZZ;
            e = vec((k == 3) ? 1'b0 : 1'b1, 1, 1, (k < 3) ? exp_timeout : 1'b0, 0,
                    st, exp_rounds, exp_tl);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s_start k=%0d got %b want %b", name, k, obs, e);
            end
        end
        host_go_n = 1'b1;
        exp_timeout = 1'b0;
    endtask

    // One full round: judge presses at cycle offsets d_ok/d_bad after ANSWER entry (-1 = none).
    task automatic run_round(input int d_ok, input int d_bad, input bit win,
                             input logic [2:0] player, input string name);
        int t_ok, t_bad, t_dec, r_new, tl_k, st, rc;
        bit ok_v, expired, over, to_k;
        logic [16:0] e;
        t_ok  = (d_ok  >= 0 && d_ok  + 2 <= LIM) ? d_ok  + 2 : NONE;
        t_bad = (d_bad >= 0 && d_bad + 2 <= LIM) ? d_bad + 2 : NONE;
        if (t_ok != NONE && t_ok <= t_bad) begin
            ok_v = 1'b1; expired = 1'b0; t_dec = t_ok;
        end else if (t_bad != NONE) begin
            ok_v = 1'b0; expired = 1'b0; t_dec = t_bad;
        end else begin
            ok_v = 1'b0; expired = 1'b1; t_dec = LIM;
        end
        r_new = (exp_rounds == 31) ? 31 : exp_rounds + 1;
        over  = win || (r_new == MR);

        start_round(name);
        P = player;
        for (int k = 0; k <= t_dec + 4; k++) begin
            @(negedge clk);
            tl_k = AT - (((k < t_dec + 1) ? k : t_dec + 1) / TD);
            if (tl_k < 0) tl_k = 0;
            if (k <= t_dec)          st = ST_ANSWER;
            else if (k == t_dec + 1) st = ST_JUDGE;
            else if (k <= t_dec + 3) st = ST_CHECK;
            else                     st = over ? ST_OVER : ST_IDLE;
            rc   = (k <= t_dec + 1) ? exp_rounds : r_new;
            to_k = (k <= t_dec) ? 1'b0 : expired;
            e = vec(1, !(k == t_dec + 1 && ok_v), !(k == t_dec + 1 && !ok_v), to_k,
                    (k == t_dec + 4) && over, st, rc, tl_k);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s k=%0d got %b want %b", name, k, obs, e);
            end
            if (k == d_ok)      judge_ok_n  = 1'b0;
            if (k == d_bad)     judge_bad_n = 1'b0;
            if (k == d_ok + 4)  judge_ok_n  = 1'b1;
            if (k == d_bad + 4) judge_bad_n = 1'b1;
            if (k == t_dec + 1) P = 3'd0;
            if (win && k == t_dec + 2) winner = 3'd3;
        end
        judge_ok_n = 1'b1;
        judge_bad_n = 1'b1;
        exp_rounds  = r_new;
        exp_tl      = AT - ((t_dec + 1) / TD);
        if (exp_tl < 0) exp_tl = 0;
        exp_timeout = expired;
        exp_over    = over;
        if (!over) repeat (2) @(negedge clk);
    endtask

    // After game over a host press must produce no strobe and no state change.
    task automatic check_go_ignored(input string name);
        logic [16:0] e;
        host_go_n = 1'b0;
        e = vec(1, 1, 1, exp_timeout, 1, ST_OVER, exp_rounds, exp_tl);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s k=%0d got %b want %b", name, k, obs, e);
            end
        end
        host_go_n = 1'b1;
    endtask

    task automatic test_ok_round();
        apply_reset("reset_ok");
        run_round(TD, -1, 1'b0, 3'd2, "ok_tick1");
    endtask

    task automatic test_timeout();
        apply_reset("reset_to");
        run_round(-1, -1, 1'b0, 3'd1, "timeout");
        run_round(LIM - 2, -1, 1'b0, 3'd4, "ok_at_expiry");
    endtask

    task automatic test_both_pressed();
        apply_reset("reset_both");
        run_round(5, 5, 1'b0, 3'd3, "both_same");
    endtask

    task automatic test_winner();
        apply_reset("reset_win");
        run_round(2, -1, 1'b1, 3'd4, "winner");
        check_go_ignored("win_go_ignored");
    endtask

    task automatic test_max_rounds();
        apply_reset("reset_max");
        run_round(-1, 3, 1'b0, 3'd1, "max_r1");
        run_round(7, -1, 1'b0, 3'd2, "max_r2");
        check_go_ignored("max_go_ignored");
    endtask

    task automatic test_random_games();
        int d_ok, d_bad;
        bit win;
        for (int g = 0; g < 6; g++) begin
            apply_reset("reset_rand");
            while (!exp_over) begin
                d_ok  = int'($urandom_range(0, 15)) - 1;
                d_bad = int'($urandom_range(0, 15)) - 1;
                win   = ($urandom_range(0, 3) == 0);
                run_round(d_ok, d_bad, win, 3'($urandom_range(1, 4)), "rand");
            end
            check_go_ignored("rand_go_ignored");
        end
    endtask

    task automatic test_reset_mid();
        apply_reset("reset_pre_mid");
        run_round(3, -1, 1'b0, 3'd2, "pre_mid");
        start_round("mid");
        P = 3'd2;
        repeat (5) @(negedge clk);
        apply_reset("reset_mid_answer");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ok_round();
        test_timeout();
        test_both_pressed();
        test_winner();
        test_max_rounds();
        test_random_games();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quiz_host_console.md
# quiz_host_console

Host-side sequencer for the four-player quiz buzzer. It drives the buzzer's active-low host-start (`h`) and judge (`jt` correct, `jf` wrong) strobes from debounced operator buttons. It watches the buzzer's answering-player code (`P`) and winner code, enforces a per-answer time limit, counts rounds and declares game over. It sits on the same `clk` as the buzzer and connects to it port-for-port.

## Interface
- `TICK_DIV`, default 50_000_000: clk cycles per countdown tick (1 s at 50 MHz).
- `ANSWER_TIME`, default 10: ticks allowed to answer after a buzz-in, range 1..15.
- `MAX_ROUNDS`, default 20: rounds after which the game ends, range 1..31.
- `clk`  in  1  system clock, shared with the buzzer.
- `reset`  in  1  asynchronous, active-low.
- `host_go_n`  in  1  host "next question" button, active-low, asynchronous.
- `judge_ok_n`  in  1  judge "correct" button, active-low, asynchronous.
- `judge_bad_n`  in  1  judge "wrong" button, active-low, asynchronous.
- `P`  in  3  answering player from the buzzer; 0 = none, 1..4 = player.
- `winner`  in  3  winner code from the buzzer; 0 = none.
- `h`  out  1  host-start strobe to the buzzer, active-low.
- `jt`  out  1  correct strobe to the buzzer, active-low.
- `jf`  out  1  wrong strobe to the buzzer, active-low.
- `time_left`  out  4  remaining answer ticks, for display.
- `round_cnt`  out  5  completed rounds.
- `state_o`  out  3  current state encoding.
- `timeout`  out  1  high while the last verdict came from time expiry.
- `game_over`  out  1  game has ended.

## Operation
- Each button passes through a 2-FF synchronizer and a falling-edge detector. This gives a 1-cycle `*_ev` pulse per press; a held button gives no repeat.
- States: IDLE, ARM, BUZZ, ANSWER, JUDGE, CHECK, OVER.
  - IDLE: `go_ev` -> ARM.
  - ARM: `h`=0 for exactly 1 cycle, then BUZZ.
  - BUZZ: wait indefinitely for `P`!=0. On `P`!=0, load `time_left`=ANSWER_TIME, clear the tick divider and go to ANSWER. Judge events in BUZZ are ignored.
  - ANSWER: divider counts 0..TICK_DIV-1; at wrap, `time_left` decrements.
    - `ok_ev` -> JUDGE with verdict correct.
    - `bad_ev` -> JUDGE with verdict wrong.
    - `time_left`=0 -> JUDGE with verdict wrong and `timeout` set.
    - Priority: `ok_ev` > `bad_ev` > timeout.
  - JUDGE: `jt`=0 (correct) or `jf`=0 (wrong) for exactly 1 cycle; `round_cnt`+1 (saturating at 31); then CHECK.
  - CHECK: lasts 2 cycles, because the buzzer's winner register lags the score by one cycle. On the 2nd cycle:
    - `winner`!=0 or `round_cnt`==MAX_ROUNDS -> OVER.
    - Otherwise -> IDLE.
  - OVER: `game_over`=1; all events ignored; exit only by `reset`.
- `timeout` clears on the next ARM.
- `go_ev` outside IDLE is ignored; it is not queued.
- Only one of `h`/`jt`/`jf` is ever low in a given cycle.

## Timing
- Reset values:
  - `h`=`jt`=`jf`=1.
  - `time_left`=0, `round_cnt`=0.
  - State IDLE, so `state_o`=0.
  - `timeout`=0, `game_over`=0.
  - Synchronizer flops = 1, so releasing reset while a button is held causes no event.
- Button press to `h` low: 3 cycles (2 sync + 1 edge/state).
- `P`!=0 sampled in BUZZ -> ANSWER next cycle.
- The verdict strobe is low the cycle after the decision; the buzzer samples it on the following edge.
- Timeout strobe `jf` is low exactly ANSWER_TIME*TICK_DIV+1 cycles after entering ANSWER.
- JUDGE to IDLE/OVER: 3 cycles.
- Reset mid-round: all strobes return high immediately and counters clear. The buzzer is reset by the same net.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `quiz_pkg` holds:
  - State encodings (IDLE=0 .. OVER=6).
  - `STROBE_ON`=1'b0 / `STROBE_OFF`=1'b1.
  - Player code width (3).
- Sub-module `btn_edge_sync`: 2-FF synchronizer plus falling-edge detector, reset value 1, instantiated three times.
- The main FSM, tick divider and countdown live in `quiz_host_console`.

## Test plan
- Reset, press `host_go_n` -> `h` low for 1 cycle 3 cycles later; state BUZZ; `jt`/`jf` stay 1.
- TICK_DIV=4, ANSWER_TIME=3; after ARM, set `P`=2, then press `judge_ok_n` at tick 1 -> `jt` low 1 cycle; `round_cnt`=1; back to IDLE 3 cycles later.
- Same parameters, no judge press -> `time_left` reads 3,2,1,0; `jf` low at cycle 13 after ANSWER entry; `timeout`=1.
- `judge_ok_n` and `judge_bad_n` pressed in the same cycle -> only `jt` strobes.
- `winner`=3 asserted one cycle after `jt` -> OVER, `game_over`=1; a later `host_go_n` press gives no `h` strobe.
- MAX_ROUNDS=2: two full rounds -> OVER. Assert `reset` during ANSWER -> all strobes 1, `round_cnt`=0, state IDLE.
